dec_unbinder_pack: RTL and testbench

Sequential unbinder for the sparse HDC datapath: the inverse of the encoder's binder pack. It accepts one bound hypervector and undoes the per-feature binding shift for each of the FEATURES_PER_CC features in turn. Each recovered level-hypervector candidate is streamed out with a valid/ready handshake. It sits between the decoder's bound-HV source and the level-item similarity search.

---
 rtl/hdc_pkg.sv | 23 ++
 rtl/dec_unbinder_pack_if.sv | 29 ++
 rtl/hv_rotr.sv | 12 +
 rtl/dec_unbinder_pack.sv | 128 ++++++++++++
 tb/tb_dec_unbinder_pack.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// Shared HDC constants: hypervector width, features per cluster and the binding
// shift table used by both the encoder binder and this unbinder.
package hdc_pkg;

    localparam int HV_DIM          = 16;
    localparam int FEATURES_PER_CC = 4;
    localparam int N_SHIFTS        = 4;
    localparam int SHIFT_IDX_W     = (N_SHIFTS > 1) ? $clog2(N_SHIFTS) : 1;

    // Entry i is the left rotation the binder applies to feature i.
    localparam logic [N_SHIFTS-1:0][31:0] SHIFTS = {32'd17, 32'd0, 32'd3, 32'd1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] shift_at(input logic [SHIFT_IDX_W-1:0] i);
        return SHIFTS[i];
    endfunction

endpackage

// File: rtl/dec_unbinder_pack_if.sv
// Handshake bundle between the bound-HV source, the unbinder and the
// level-item similarity search.
interface dec_unbinder_pack_if #(
    parameter int HV_DIM = hdc_pkg::HV_DIM,
    parameter int IDX_W  = (hdc_pkg::FEATURES_PER_CC > 1) ? $clog2(hdc_pkg::FEATURES_PER_CC) : 1
);
    logic              start_decoding;
    logic              en;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] bound_hv;
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] out_hv;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              done;

    modport master (
        output start_decoding, en, abort, in_valid, bound_hv, out_ready,
        input  in_ready, out_valid, out_hv, out_idx, out_last, done
    );

    modport slave (
        input  start_decoding, en, abort, in_valid, bound_hv, out_ready,
        output in_ready, out_valid, out_hv, out_idx, out_last, done
    );
endinterface

// File: rtl/hv_rotr.sv
// Combinational right rotation: rot[j] = hv[(j + shift) mod HV_DIM].
// The caller keeps shift below HV_DIM.
module hv_rotr #(
    parameter int HV_DIM = 16,
    parameter int SH_W   = (HV_DIM > 1) ? $clog2(HV_DIM) : 1
) (
    input  logic [HV_DIM-1:0] hv,
    input  logic [SH_W-1:0]   shift,
    output logic [HV_DIM-1:0] rot
);
    assign rot = HV_DIM'({hv, hv} >> shift);
endmodule

// File: rtl/dec_unbinder_pack.sv
// Sequential unbinder: takes one bound hypervector and streams one unbound
// candidate per feature, undoing each feature's binder rotation.
//
// state   | meaning
// IDLE    | waiting for a qualified bound HV, in_ready high
// EMIT    | presenting feature idx beat, advance on out_ready
// DONE    | one-cycle done pulse after the last beat
module dec_unbinder_pack #(
    parameter int HV_DIM          = hdc_pkg::HV_DIM,
    parameter int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
    parameter int SHIFT_BASE      = 0,
    parameter int IDX_W           = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1
) (
    input logic                clk,
    input logic                nrst,
    dec_unbinder_pack_if.slave bus
);
    import hdc_pkg::*;

    localparam int               SH_W     = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES_PER_CC - 1);

    state_t            state_q;
    state_t            state_d;
    logic              load;
    logic              accept;
    logic              is_last;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IDX_W-1:0]  rot_idx;
    logic [HV_DIM-1:0] hv_reg;
    logic [HV_DIM-1:0] rot_src;
    logic [HV_DIM-1:0] rot_hv;
    logic [SH_W-1:0]   rot_shift;
    logic [HV_DIM-1:0] out_hv_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              done_q;

    assign is_last = (idx_q == LAST_IDX);
    assign nxt_idx = is_last ? '0 : idx_q + IDX_W'(1);

    // One rotator serves both the first beat (straight from bound_hv on load)
    // and every following beat (from hv_reg for the next feature).
    assign rot_src   = (state_q == ST_IDLE) ? bus.bound_hv : hv_reg;
    assign rot_idx   = (state_q == ST_IDLE) ? '0 : nxt_idx;
    assign rot_shift = SH_W'(shift_at(SHIFT_IDX_W'(SHIFT_BASE) + SHIFT_IDX_W'(rot_idx))
                             % 32'(HV_DIM));

    hv_rotr #(
        .HV_DIM (HV_DIM),
        .SH_W   (SH_W)
    ) u_rotr (
        .hv    (rot_src),
        .shift (rot_shift),
        .rot   (rot_hv)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && bus.start_decoding && bus.en) begin
                    load    = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort wins over both a load and a beat acceptance
        if (bus.abort) begin
            state_d = ST_IDLE;
            load    = 1'b0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            hv_reg      <= '0;
            idx_q       <= '0;
            out_hv_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_EMIT);
            done_q      <= (state_d == ST_DONE);
            if (load) begin
                hv_reg     <= bus.bound_hv;
                idx_q      <= '0;
                out_hv_q   <= rot_hv;
                out_last_q <= (LAST_IDX == '0);
            end else if (accept && !is_last) begin
                idx_q      <= nxt_idx;
                out_hv_q   <= rot_hv;
                out_last_q <= (nxt_idx == LAST_IDX);
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_hv    = out_hv_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dec_unbinder_pack.sv
// Bench for dec_unbinder_pack: fixed vector table, hand-written corner
// sequences, and random round trips against a bit-level rotation model.
module tb_dec_unbinder_pack;

    localparam int N = 16;

    typedef struct {
        logic [15:0]      hv;
        logic [3:0][15:0] beats;
    } vec_t;

    logic clk = 1'b0;
    logic nrst;
    int   total = 0;
    int   bad = 0;
    vec_t tbl [5];

    always #5 clk = ~clk;

    dec_unbinder_pack_if #(.HV_DIM(16), .IDX_W(2)) bus ();

    dec_unbinder_pack #(
        .HV_DIM          (16),
        .FEATURES_PER_CC (4),
        .SHIFT_BASE      (0),
        .IDX_W           (2)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    function automatic int sh_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 0;
            default: return 17;
        endcase
    endfunction

    function automatic logic [15:0] rotr_m(input logic [15:0] v, input int s);
        logic [15:0] r;
        for (int j = 0; j < N; j++) r[j] = v[(j + s) % N];
        return r;
    endfunction

    function automatic logic [15:0] rotl_m(input logic [15:0] v, input int s);
        logic [15:0] r;
        for (int j = 0; j < N; j++) r[(j + s) % N] = v[j];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.start_decoding = 1'b0;
        bus.en             = 1'b0;
        bus.abort          = 1'b0;
    endtask

    task automatic load_hv(input logic [15:0] hv);
        bus.in_valid       = 1'b1;
        bus.start_decoding = 1'b1;
        bus.en             = 1'b1;
        bus.bound_hv       = hv;
        @(negedge clk);
        idle_inputs();
        bus.bound_hv = 16'(($urandom));
    endtask

    // Back-to-back beats with out_ready held high; exact cycle timing.
    task automatic do_strict(input logic [15:0] hv, input logic [3:0][15:0] beats);
        chk("pre_load_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        load_hv(hv);
        for (int i = 0; i < 4; i++) begin
            chk("strict_valid", bus.out_valid, 1);
            chk("strict_idx", bus.out_idx, i);
            chk("strict_hv", bus.out_hv, beats[i]);
            chk("strict_last", bus.out_last, (i == 3));
            chk("strict_busy", bus.in_ready, 0);
            @(negedge clk);
        end
        chk("strict_done", bus.done, 1);
        chk("strict_done_valid", bus.out_valid, 0);
        chk("strict_done_busy", bus.in_ready, 0);
        @(negedge clk);
        chk("strict_done_width", bus.done, 0);
        chk("strict_back_idle", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    // Handshake-level model: beats must arrive in order 0..3, hold while stalled,
    // and match rotr(bound, shift); beat f must also recover orig.
    task automatic run_model(input logic [15:0] hv, input logic [15:0] orig, input int f,
                             input bit use_rand, input logic [31:0] pat);
        int          next_k = 0;
        int          cyc = 0;
        bit          fin = 0;
        bit          pv = 0;
        bit          pr = 0;
        logic        rdy;
        logic [15:0] ph = '0;
        logic [1:0]  pi = '0;
        logic        pl = 1'b0;
        bus.out_ready = 1'b0;
        load_hv(hv);
        while (!fin && cyc < 64) begin
            rdy = 1'b0;
            if (bus.out_valid) begin
                if (pv && !pr) begin
                    chk("hold_hv", bus.out_hv, ph);
                    chk("hold_idx", bus.out_idx, pi);
                    chk("hold_last", bus.out_last, pl);
                end
                chk("beat_idx", bus.out_idx, next_k);
                chk("beat_hv", bus.out_hv, rotr_m(hv, sh_of(next_k)));
                chk("beat_last", bus.out_last, (next_k == 3));
                if (next_k == f) chk("round_trip", bus.out_hv, orig);
                chk("busy_in_ready", bus.in_ready, 0);
                rdy = use_rand ? 1'($urandom_range(0, 1)) : pat[cyc];
                pv = 1; pr = rdy;
                ph = bus.out_hv; pi = bus.out_idx; pl = bus.out_last;
                if (rdy) next_k++;
            end else if (bus.done) begin
                chk("beats_before_done", next_k, 4);
                chk("done_busy", bus.in_ready, 0);
                fin = 1;
            end else begin
                chk("busy_valid", bus.out_valid, 1);
                pv = 0;
            end
            bus.out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout: no done after %0d cycles", cyc);
        end
        chk("model_done_width", bus.done, 0);
        chk("model_back_idle", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] orig;
        int          f;

        tbl[0].hv = 16'h0001; tbl[0].beats = {16'h8000, 16'h0001, 16'h2000, 16'h8000};
        tbl[1].hv = 16'h8001; tbl[1].beats = {16'hC000, 16'h8001, 16'h3000, 16'hC000};
        tbl[2].hv = 16'h00F0; tbl[2].beats = {16'h0078, 16'h00F0, 16'h001E, 16'h0078};
        tbl[3].hv = 16'h1234; tbl[3].beats = {16'h091A, 16'h1234, 16'h8246, 16'h091A};
        tbl[4].hv = 16'hFFFF; tbl[4].beats = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        nrst = 1'b1;
        idle_inputs();
        bus.bound_hv  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_hv", bus.out_hv, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);

        for (int i = 0; i < 5; i++) do_strict(tbl[i].hv, tbl[i].beats);

        // Gating: in_valid without start_decoding && en must not load
        bus.in_valid = 1'b1; bus.bound_hv = 16'hAAAA;
        bus.en = 1'b0; bus.start_decoding = 1'b1;
        @(negedge clk);
        chk("gate_en0_valid", bus.out_valid, 0);
        chk("gate_en0_ready", bus.in_ready, 1);
        bus.en = 1'b1; bus.start_decoding = 1'b0;
        @(negedge clk);
        chk("gate_start0_valid", bus.out_valid, 0);
        chk("gate_start0_ready", bus.in_ready, 1);
        idle_inputs();
        do_strict(tbl[2].hv, tbl[2].beats);

        // Abort in the same cycle as a qualified load
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.start_decoding = 1'b1; bus.en = 1'b1;
        bus.abort = 1'b1; bus.bound_hv = 16'h5555;
        @(negedge clk);
        idle_inputs();
        chk("abort_load_valid", bus.out_valid, 0);
        chk("abort_load_ready", bus.in_ready, 1);

        // Abort during idx2 with out_ready high
        load_hv(16'h0001);
        @(negedge clk);
        @(negedge clk);
        chk("abort_at_idx2", bus.out_idx, 2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("abort_no_done", bus.done, 0);
        chk("abort_no_beat", bus.out_valid, 0);
        do_strict(tbl[3].hv, tbl[3].beats);

        // Asynchronous reset in the middle of EMIT
        bus.out_ready = 1'b1;
        load_hv(16'h00F0);
        @(negedge clk);
        #2 nrst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_hv", bus.out_hv, 0);
        chk("arst_out_idx", bus.out_idx, 0);
        chk("arst_out_last", bus.out_last, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("arst_no_beat", bus.out_valid, 0);
        chk("arst_no_done", bus.done, 0);
        bus.out_ready = 1'b0;
        do_strict(tbl[1].hv, tbl[1].beats);

        // Backpressure pattern 1,0,0,1 then ready
        run_model(16'h1234, 16'h0000, -1, 1'b0, 32'hFFFF_FFF9);
        run_model(16'h8001, 16'h0000, -1, 1'b0, 32'hFFFF_FFF9);

        // Random round trips with random backpressure
        for (int n = 0; n < 1000; n++) begin
            orig = 16'($urandom);
            f    = int'($urandom_range(0, 3));
            run_model(rotl_m(orig, sh_of(f)), orig, f, 1'b1, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
